// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales each incoming sample by an envelope level
// that advances once per sample tick and is steered by the key gate.
module adsr_envelope #(
    parameter logic [7:0] ATTACK_STEP  = 8'd32,
    parameter logic [7:0] DECAY_STEP   = 8'd8,
    parameter logic [7:0] SUSTAIN_LVL  = 8'd160,
    parameter logic [7:0] RELEASE_STEP = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [7:0] sample_i,
    input  logic       sample_valid_i,
    output logic [7:0] sample_o,
    output logic       sample_valid_o,
    output logic [7:0] env_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] env_q, env_d;
    logic       gate_q, gate_d;
    logic [7:0] sample_q, sample_d;
    logic       valid_q, valid_d;

    logic       rise_s, fall_s;
    logic [8:0] attack_sum_s;
    logic [8:0] decay_floor_s;
    logic [7:0] scaled_s;

    // Next-state, envelope step and output scaling
    always_comb begin
        gate_d        = gate;
        rise_s        = gate & ~gate_q;
        fall_s        = ~gate & gate_q;
        attack_sum_s  = {1'b0, env_q} + {1'b0, ATTACK_STEP};
        decay_floor_s = {1'b0, SUSTAIN_LVL} + {1'b0, DECAY_STEP};
        scaled_s      = 8'(({8'd0, sample_i} * {8'd0, env_q}) >> 8);

        state_d = state_q;
        env_d   = env_q;

        // A gate edge takes priority over the envelope step in the same cycle
        if (rise_s && (state_q == IDLE || state_q == RELEASE)) begin
            state_d = ATTACK;
        end else if (fall_s && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (sample_valid_i && !rise_s && !fall_s) begin
            case (state_q)
                IDLE: begin
                    env_d = 8'd0;
                end
                ATTACK: begin
                    if (attack_sum_s >= 9'd255) begin
                        env_d   = 8'd255;
                        state_d = DECAY;
                    end else begin
                        env_d = attack_sum_s[7:0];
                    end
                end
                DECAY: begin
                    if ({1'b0, env_q} <= decay_floor_s) begin
                        env_d   = SUSTAIN_LVL;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = env_q - DECAY_STEP;
                    end
                end
                SUSTAIN: begin
                    env_d = env_q;
                end
                RELEASE: begin
                    if (env_q <= RELEASE_STEP) begin
                        env_d   = 8'd0;
                        state_d = IDLE;
                    end else begin
                        env_d = env_q - RELEASE_STEP;
                    end
                end
                default: begin
                    env_d   = 8'd0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
            env_d   = env_q;
        end

        valid_d = sample_valid_i;
        if (sample_valid_i) begin
            sample_d = (env_q == 8'd255) ? sample_i : scaled_s;
        end else begin
            sample_d = sample_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            env_q    <= 8'd0;
            gate_q   <= 1'b0;
            sample_q <= 8'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            gate_q   <= gate_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign env_o          = env_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a behavioural envelope model and a
// queue scoreboard for the scaled output samples.
module tb_adsr_envelope;

    localparam int AS = 32;
    localparam int DS = 8;
    localparam int SL = 160;
    localparam int RS = 4;

    logic       clk;
    logic       rst;
    logic       gate;
    logic [7:0] sample_i;
    logic       sample_valid_i;
    logic [7:0] sample_o;
    logic       sample_valid_o;
    logic [7:0] env_o;
    logic [2:0] state_o;

    int         checks;
    int         failures;
    int         m_env;
    int         m_state;
    logic       m_gate_q;
    logic       last_tick;
    logic [7:0] sb[$];

    adsr_envelope dut (
        .clk            (clk),
        .rst            (rst),
        .gate           (gate),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .env_o          (env_o),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] scale(input logic [7:0] s, input int e);
        int p;
        if (e == 255) return s;
        p = int'(s) * e;
        return 8'(p / 256);
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge
    task automatic step(input logic r, input logic g, input logic t, input logic [7:0] s);
        logic rise, fall;
        logic [7:0] e;
        rst = r; gate = g; sample_valid_i = t; sample_i = s;
        @(posedge clk);
        if (r) begin
            m_state = 0; m_env = 0; m_gate_q = 1'b0; last_tick = 1'b0;
            sb.delete();
        end else begin
            rise = g & ~m_gate_q;
            fall = ~g & m_gate_q;
            if (t) sb.push_back(scale(s, m_env));
            last_tick = t;
            if (rise && (m_state == 0 || m_state == 4)) begin
                m_state = 1;
            end else if (fall && m_state >= 1 && m_state <= 3) begin
                m_state = 4;
            end else if (t && !rise && !fall) begin
                case (m_state)
                    1: begin
                        m_env = m_env + AS;
                        if (m_env >= 255) begin m_env = 255; m_state = 2; end
                    end
                    2: begin
                        m_env = m_env - DS;
                        if (m_env <= SL) begin m_env = SL; m_state = 3; end
                    end
                    4: begin
                        m_env = m_env - RS;
                        if (m_env <= 0) begin m_env = 0; m_state = 0; end
                    end
                    default: ;
                endcase
            end
            m_gate_q = g;
        end
        @(negedge clk);
        chk("valid_o", {8'd0, sample_valid_o}, {8'd0, last_tick});
        if (sample_valid_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=valid expected=no_output");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sample_o", {1'b0, sample_o}, {1'b0, e});
            end
        end else if (last_tick && sb.size() != 0) begin
            e = sb.pop_front();
        end
        chk("env_o", {1'b0, env_o}, 9'(m_env));
        chk("state_o", {6'd0, state_o}, 9'(m_state));
    endtask

    initial begin
        checks = 0; failures = 0;
        m_env = 0; m_state = 0; m_gate_q = 1'b0; last_tick = 1'b0;
        rst = 1'b1; gate = 1'b0; sample_i = 8'd0; sample_valid_i = 1'b0;
        @(negedge clk);

        // 1: reset with gate high and ticks present
        step(1'b1, 1'b1, 1'b1, 8'd200);
        step(1'b1, 1'b1, 1'b1, 8'd200);
        chk("rst_sample", {1'b0, sample_o}, 9'd0);
        chk("rst_state", {6'd0, state_o}, 9'd0);
        step(1'b0, 1'b1, 1'b0, 8'd200);
        chk("post_rst_attack", {6'd0, state_o}, 9'd1);

        // 2: attack with ticks every 256 clocks
        for (int k = 1; k <= 8; k++) begin
            repeat (255) step(1'b0, 1'b1, 1'b0, 8'd200);
            step(1'b0, 1'b1, 1'b1, 8'd200);
            if (k == 2) chk("scaled_env32", {1'b0, sample_o}, 9'd25);
        end
        chk("attack_top", {1'b0, env_o}, 9'd255);
        chk("attack_to_decay", {6'd0, state_o}, 9'd2);

        // 3: decay to sustain
        for (int k = 1; k <= 12; k++) begin
            repeat (3) step(1'b0, 1'b1, 1'b0, 8'd200);
            step(1'b0, 1'b1, 1'b1, 8'd200);
            if (k == 1) chk("passthru_env255", {1'b0, sample_o}, 9'd200);
            if (k == 11) chk("decay_167", {1'b0, env_o}, 9'd167);
        end
        chk("sustain_lvl", {1'b0, env_o}, 9'd160);
        chk("sustain_state", {6'd0, state_o}, 9'd3);
        repeat (2) step(1'b0, 1'b1, 1'b1, 8'd77);
        chk("sustain_hold", {1'b0, env_o}, 9'd160);

        // 4: release to idle, then idle ticks emit zero
        step(1'b0, 1'b0, 1'b0, 8'd200);
        chk("fall_release", {6'd0, state_o}, 9'd4);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 1'b1, 8'(k * 5 + 3));
            step(1'b0, 1'b0, 1'b0, 8'd0);
        end
        chk("release_end_env", {1'b0, env_o}, 9'd0);
        chk("release_end_idle", {6'd0, state_o}, 9'd0);
        step(1'b0, 1'b0, 1'b1, 8'd200);
        chk("idle_sample_zero", {1'b0, sample_o}, 9'd0);

        // 5: bring envelope back to release at env 100, then retrigger
        step(1'b0, 1'b1, 1'b0, 8'd200);
        repeat (8) step(1'b0, 1'b1, 1'b1, 8'd150);
        repeat (12) step(1'b0, 1'b1, 1'b1, 8'd150);
        step(1'b0, 1'b0, 1'b0, 8'd150);
        repeat (15) step(1'b0, 1'b0, 1'b1, 8'd180);
        chk("release_env100", {1'b0, env_o}, 9'd100);
        step(1'b0, 1'b1, 1'b1, 8'd200);
        chk("retrig_state", {6'd0, state_o}, 9'd1);
        chk("retrig_env_kept", {1'b0, env_o}, 9'd100);
        chk("retrig_sample", {1'b0, sample_o}, 9'd78);
        step(1'b0, 1'b1, 1'b0, 8'd200);
        step(1'b0, 1'b1, 1'b1, 8'd200);
        chk("retrig_env132", {1'b0, env_o}, 9'd132);

        // 6: back-to-back ticks
        step(1'b0, 1'b1, 1'b1, 8'd10);
        step(1'b0, 1'b1, 1'b1, 8'd128);
        step(1'b0, 1'b1, 1'b1, 8'd255);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("b2b_env", {1'b0, env_o}, 9'd228);

        // Reset mid-envelope drops the in-flight pulse
        step(1'b0, 1'b1, 1'b1, 8'd100);
        step(1'b1, 1'b1, 1'b1, 8'd50);
        chk("midrst_state", {6'd0, state_o}, 9'd0);
        chk("midrst_valid", {8'd0, sample_valid_o}, 9'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd99);
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("sb_drained", 9'(sb.size()), 9'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
